// File: rtl/instr_prefetch_unit_if.sv
// Instruction-memory port of the prefetch unit: a valid/ready request channel
// and an in-order, never back-pressured response channel.
interface instr_prefetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Fetch front end ahead of IF/ID: credit-limited requests to instruction memory,
// a DEPTH-entry {PC, instr} queue, and redirect handling that discards stale words.
module instr_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         StallF,
  input  logic                         PCSrcE,
  input  logic [31:0]                  PCTargetE,
  instr_prefetch_unit_if.master        imem,
  output logic [31:0]                  InstrF,
  output logic [31:0]                  PCF,
  output logic [31:0]                  PCPlus4F,
  output logic                         instr_valid
);

  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam int unsigned   CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;

  logic [31:0]   pcQ    [DEPTH];
  logic [31:0]   instrQ [DEPTH];
  logic [PW-1:0] rdPtr, rdPtrNext;
  logic [PW-1:0] wrPtr, wrPtrNext;
  logic [CW-1:0] count, countNext;
  logic [CW-1:0] inflight, inflightNext;
  logic [CW-1:0] discard, discardNext;
  logic [31:0]   fetchPc, fetchPcNext;
  logic [31:0]   rspPc, rspPcNext;
  logic [31:0]   targetPc;
  logic [CW:0]   occupancy;
  logic          fetchEnable;
  logic          reqValid;
  logic          handshake;
  logic          rspLegal;
  logic          rspKeep;
  logic          popEn;

  // Queued words plus outstanding requests never exceed DEPTH, so every
  // response has a slot waiting for it and the response port never stalls.
  assign targetPc   = PCTargetE & 32'hFFFF_FFFC;
  assign occupancy  = {1'b0, count} + {1'b0, inflight};
  assign reqValid   = fetchEnable && !PCSrcE && (occupancy < {1'b0, DEPTH_C});
  assign handshake  = reqValid && imem.imem_req_ready;
  assign rspLegal   = imem.imem_rsp_valid && (inflight != '0);
  assign rspKeep    = rspLegal && (discard == '0) && !PCSrcE;
  assign popEn      = instr_valid && !StallF && !PCSrcE;

  assign imem.imem_req_valid = reqValid;
  assign imem.imem_req_addr  = fetchPc;

  always_comb begin
    rdPtrNext    = rdPtr;
    wrPtrNext    = wrPtr;
    countNext    = count;
    inflightNext = inflight;
    discardNext  = discard;
    fetchPcNext  = fetchPc;
    rspPcNext    = rspPc;
    if (PCSrcE) begin
      // Everything still outstanding belongs to the old path: the words already
      // marked for discard plus the live ones, minus any response arriving now.
      rdPtrNext    = '0;
      wrPtrNext    = '0;
      countNext    = '0;
      fetchPcNext  = targetPc;
      rspPcNext    = targetPc;
      inflightNext = inflight - CW'(rspLegal);
      discardNext  = inflight - CW'(rspLegal);
    end else begin
      inflightNext = inflight + CW'(handshake) - CW'(rspLegal);
      countNext    = count + CW'(rspKeep) - CW'(popEn);
      if (rspLegal && (discard != '0)) begin
        discardNext = discard - 1'b1;
      end
      if (handshake) begin
        fetchPcNext = fetchPc + 32'd4;
      end
      if (rspKeep) begin
        rspPcNext = rspPc + 32'd4;
        wrPtrNext = wrPtr + 1'b1;
      end
      if (popEn) begin
        rdPtrNext = rdPtr + 1'b1;
      end
    end
  end

  // fetchEnable holds off the first request until the cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      inflight    <= '0;
      discard     <= '0;
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      fetchEnable <= 1'b0;
    end else begin
      rdPtr       <= rdPtrNext;
      wrPtr       <= wrPtrNext;
      count       <= countNext;
      inflight    <= inflightNext;
      discard     <= discardNext;
      fetchPc     <= fetchPcNext;
      rspPc       <= rspPcNext;
      fetchEnable <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rspKeep) begin
      pcQ[wrPtr]    <= rspPc;
      instrQ[wrPtr] <= imem.imem_rsp_data;
    end
  end

  assign instr_valid = (count != '0);
  assign InstrF      = instr_valid ? instrQ[rdPtr] : NOP_INSTR;
  assign PCF         = instr_valid ? pcQ[rdPtr] : 32'h0000_0000;
  assign PCPlus4F    = PCF + 32'd4;

  rspNeedsRequest: assert property (@(posedge clk) disable iff (!reset_n)
    imem.imem_rsp_valid |-> (inflight != '0));

  discardBounded: assert property (@(posedge clk) disable iff (!reset_n)
    discard <= inflight);

  creditBounded: assert property (@(posedge clk) disable iff (!reset_n)
    occupancy <= {1'b0, DEPTH_C});

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: directed scenarios plus a randomized
// run against a stream-level model (consumed PCs must run sequentially from the last redirect).
module tb_instr_prefetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        instr_valid;

  instr_prefetch_unit_if imem ();

  instr_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem        (imem),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  int          cycleNo    = 0;
  int          lastDue    = 0;
  int          memLat     = 1;
  bit          randLat    = 1'b0;
  logic [31:0] pendAddr [$];
  int          pendDue  [$];

  logic        sReqValid, sHs, sRsp, sValid;
  logic [31:0] sReqAddr, sPcf, sInstr, sPc4;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model drives its response for the current cycle, then outputs are sampled.
  task automatic driveCycle();
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    if (pendAddr.size() > 0 && pendDue[0] <= cycleNo) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = memWord(pendAddr[0]);
    end
    #1;
    sReqValid = imem.imem_req_valid;
    sReqAddr  = imem.imem_req_addr;
    sValid    = instr_valid;
    sPcf      = PCF;
    sInstr    = InstrF;
    sPc4      = PCPlus4F;
    sHs       = sReqValid && imem.imem_req_ready;
    sRsp      = imem.imem_rsp_valid;
  endtask

  task automatic clockCycle();
    int due;
    @(posedge clk);
    if (sRsp) begin
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end
    if (sHs) begin
      due = cycleNo + memLat + (randLat ? int'($urandom_range(0, 2)) : 0);
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      pendAddr.push_back(sReqAddr);
      pendDue.push_back(due);
    end
    cycleNo++;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    StallF = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    pendAddr.delete();
    pendDue.delete();
    lastDue = cycleNo;
    sHs = 1'b0;
    sRsp = 1'b0;
    memLat = 1;
    randLat = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    StallF = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    @(negedge clk);
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b want 0", instr_valid); end
    vectors++; if (InstrF !== NOP_W) begin miscompares++; $display("[TB] FAIL rst_instr: got %h want %h", InstrF, NOP_W); end
    vectors++; if (PCF !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pcf: got %h want 0", PCF); end
    vectors++; if (PCPlus4F !== 32'h4) begin miscompares++; $display("[TB] FAIL rst_pc4: got %h want 4", PCPlus4F); end
    vectors++; if (imem.imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_reqvalid: got %b want 0", imem.imem_req_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    driveCycle();
    vectors++; if (sReqAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL rst_addr: got %h want %h", sReqAddr, RESET_PC); end
    clockCycle();
  endtask

  task automatic test_sequential_fetch();
    bit          found = 1'b0;
    logic [31:0] expReq;
    logic [31:0] expPc;
    doReset();
    for (int i = 0; i < 10; i++) begin
      driveCycle();
      if (sHs) begin found = 1'b1; break; end
      clockCycle();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL seq_first_req: got no handshake want one within 10 cycles");
      return;
    end
    vectors++; if (sReqAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL seq_addr0: got %h want %h", sReqAddr, RESET_PC); end
    expReq = RESET_PC + 32'd4;
    for (int k = 1; k <= 5; k++) begin
      clockCycle();
      driveCycle();
      vectors++;
      if (sReqValid !== 1'b1 || sReqAddr !== expReq) begin
        miscompares++;
        $display("[TB] FAIL seq_req%0d: got valid=%b addr=%h want valid=1 addr=%h", k, sReqValid, sReqAddr, expReq);
      end
      expReq = expReq + 32'd4;
      if (k == 1) begin
        vectors++; if (sValid !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_latency: got valid=%b want 0 one cycle after handshake", sValid); end
      end else begin
        expPc = RESET_PC + 32'(4 * (k - 2));
        vectors++;
        if (sValid !== 1'b1 || sPcf !== expPc || sInstr !== memWord(expPc) || sPc4 !== expPc + 32'd4) begin
          miscompares++;
          $display("[TB] FAIL seq_head%0d: got v=%b pc=%h instr=%h pc4=%h want v=1 pc=%h instr=%h pc4=%h",
                   k, sValid, sPcf, sInstr, sPc4, expPc, memWord(expPc), expPc + 32'd4);
        end
      end
    end
    clockCycle();
  endtask

  task automatic test_ready_low();
    doReset();
    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      driveCycle();
      vectors++;
      if (sReqAddr !== RESET_PC || sValid !== 1'b0 || sInstr !== NOP_W) begin
        miscompares++;
        $display("[TB] FAIL ready_low%0d: got addr=%h v=%b instr=%h want addr=%h v=0 instr=%h",
                 i, sReqAddr, sValid, sInstr, RESET_PC, NOP_W);
      end
      clockCycle();
    end
    imem.imem_req_ready = 1'b1;
  endtask

  task automatic test_stall_full();
    int          hsCount = 0;
    logic [31:0] expPc;
    doReset();
    StallF = 1'b1;
    for (int i = 0; i < 10; i++) begin
      driveCycle();
      if (sHs) hsCount++;
      if (sValid) begin
        vectors++; if (sPcf !== RESET_PC) begin miscompares++; $display("[TB] FAIL stall_head: got %h want %h", sPcf, RESET_PC); end
      end
      clockCycle();
    end
    vectors++; if (hsCount != int'(DEPTH)) begin miscompares++; $display("[TB] FAIL stall_reqs: got %0d want %0d", hsCount, DEPTH); end
    StallF = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expPc = RESET_PC + 32'(4 * k);
      driveCycle();
      vectors++;
      if (sValid !== 1'b1 || sPcf !== expPc || sInstr !== memWord(expPc)) begin
        miscompares++;
        $display("[TB] FAIL stall_release%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 k, sValid, sPcf, sInstr, expPc, memWord(expPc));
      end
      clockCycle();
    end
  endtask

  task automatic test_redirect_inflight();
    bit fired = 1'b0;
    bit seen  = 1'b0;
    doReset();
    memLat = 3;
    for (int i = 0; i < 20 && !fired; i++) begin
      if (pendAddr.size() == 2 && pendDue[0] > cycleNo) begin
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0100;
        fired = 1'b1;
      end
      driveCycle();
      clockCycle();
      PCSrcE = 1'b0;
    end
    vectors++;
    if (!fired) begin
      miscompares++;
      $display("[TB] FAIL redir_setup: got no cycle with 2 in flight want one within 20 cycles");
      return;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      driveCycle();
      if (sValid) begin
        seen = 1'b1;
        vectors++;
        if (sPcf !== 32'h100 || sPc4 !== 32'h104 || sInstr !== memWord(32'h100)) begin
          miscompares++;
          $display("[TB] FAIL redir_head: got pc=%h pc4=%h instr=%h want pc=00000100 pc4=00000104 instr=%h",
                   sPcf, sPc4, sInstr, memWord(32'h100));
        end
      end
      clockCycle();
    end
    vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL redir_timeout: got no valid want valid within 20 cycles"); end
  endtask

  task automatic test_redirect_with_rsp();
    bit fired = 1'b0;
    bit seen  = 1'b0;
    doReset();
    StallF = 1'b1;
    for (int i = 0; i < 20 && !fired; i++) begin
      if (instr_valid && pendAddr.size() > 0 && pendDue[0] <= cycleNo) begin
        fired = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0203;
        driveCycle();
        vectors++; if (sReqValid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_rsp_noreq: got %b want 0", sReqValid); end
        clockCycle();
        PCSrcE = 1'b0;
        driveCycle();
        vectors++; if (sValid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_rsp_empty: got %b want 0", sValid); end
        vectors++; if (sReqAddr !== 32'h200) begin miscompares++; $display("[TB] FAIL redir_rsp_addr: got %h want 00000200", sReqAddr); end
      end else begin
        driveCycle();
      end
      clockCycle();
    end
    vectors++;
    if (!fired) begin
      miscompares++;
      $display("[TB] FAIL redir_rsp_setup: got no response cycle want one within 20 cycles");
      return;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      driveCycle();
      if (sValid) begin
        seen = 1'b1;
        vectors++;
        if (sPcf !== 32'h200 || sInstr !== memWord(32'h200)) begin
          miscompares++;
          $display("[TB] FAIL redir_rsp_head: got pc=%h instr=%h want pc=00000200 instr=%h", sPcf, sInstr, memWord(32'h200));
        end
      end
      clockCycle();
    end
    vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL redir_rsp_timeout: got no valid want valid within 20 cycles"); end
  endtask

  task automatic test_reset_midstream();
    bit found = 1'b0;
    doReset();
    StallF = 1'b1;
    for (int i = 0; i < 10; i++) begin
      driveCycle();
      clockCycle();
    end
    driveCycle();
    vectors++;
    if (sValid !== 1'b1 || sReqValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_noreq: got v=%b req=%b want v=1 req=0", sValid, sReqValid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || InstrF !== NOP_W || PCF !== 32'h0 || PCPlus4F !== 32'h4 || imem.imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_rst: got v=%b instr=%h pc=%h pc4=%h req=%b want v=0 instr=%h pc=0 pc4=4 req=0",
               instr_valid, InstrF, PCF, PCPlus4F, imem.imem_req_valid, NOP_W);
    end
    doReset();
    for (int i = 0; i < 10 && !found; i++) begin
      driveCycle();
      if (sHs) begin
        found = 1'b1;
        vectors++; if (sReqAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL post_rst_addr: got %h want %h", sReqAddr, RESET_PC); end
      end
      clockCycle();
    end
    vectors++; if (!found) begin miscompares++; $display("[TB] FAIL post_rst_req: got no handshake want one within 10 cycles"); end
  endtask

  // Reference: whatever reaches decode must be the sequential stream starting at
  // the latest redirect target, and requests likewise run sequentially from it.
  task automatic test_random();
    logic [31:0] expPc;
    logic [31:0] expReq;
    logic [31:0] tgt;
    int          idleRun = 0;
    doReset();
    randLat = 1'b1;
    expPc  = RESET_PC;
    expReq = RESET_PC;
    for (int c = 0; c < 3000; c++) begin
      imem.imem_req_ready = ($urandom_range(0, 3) != 0);
      StallF = ($urandom_range(0, 9) < 3);
      PCSrcE = ($urandom_range(0, 24) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
      PCTargetE = tgt;
      driveCycle();
      if (sValid) begin
        vectors++;
        if (sPcf !== expPc || sInstr !== memWord(expPc) || sPc4 !== expPc + 32'd4) begin
          miscompares++;
          $display("[TB] FAIL rnd_head c=%0d: got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                   c, sPcf, sInstr, sPc4, expPc, memWord(expPc), expPc + 32'd4);
        end
        idleRun = 0;
      end else begin
        vectors++;
        if (sPcf !== 32'h0 || sInstr !== NOP_W || sPc4 !== 32'h4) begin
          miscompares++;
          $display("[TB] FAIL rnd_empty c=%0d: got pc=%h instr=%h pc4=%h want pc=0 instr=%h pc4=4", c, sPcf, sInstr, sPc4, NOP_W);
        end
        idleRun++;
      end
      if (PCSrcE) begin
        vectors++; if (sReqValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_redir_req c=%0d: got %b want 0", c, sReqValid); end
        expPc  = tgt & 32'hFFFF_FFFC;
        expReq = tgt & 32'hFFFF_FFFC;
      end else begin
        if (sHs) begin
          vectors++; if (sReqAddr !== expReq) begin miscompares++; $display("[TB] FAIL rnd_addr c=%0d: got %h want %h", c, sReqAddr, expReq); end
          expReq = expReq + 32'd4;
        end
        if (sValid && !StallF) expPc = expPc + 32'd4;
      end
      vectors++; if (pendAddr.size() > DEPTH) begin miscompares++; $display("[TB] FAIL rnd_credit c=%0d: got %0d outstanding want <= %0d", c, pendAddr.size(), DEPTH); end
      vectors++;
      if (idleRun > 60) begin
        miscompares++;
        $display("[TB] FAIL rnd_progress c=%0d: got %0d idle cycles want <= 60", c, idleRun);
        idleRun = 0;
      end
      clockCycle();
    end
    PCSrcE = 1'b0;
    StallF = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    StallF = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    test_reset();
    test_sequential_fetch();
    test_ready_low();
    test_stall_full();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
